// File: rtl/dmem_responder_pkg.sv
// Shared constants for the multi-cycle data-memory responder.
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        DM_IDLE = 2'b00,
        DM_WAIT = 2'b01,
        DM_DONE = 2'b10
    } dm_state_e;

    localparam int DM_LAT = 3;

    // Word accesses need the two byte-offset bits clear.
    function automatic logic misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/dmem_responder_array.sv
// Single-port word storage; rdata is registered and loads only on a read.
module dmem_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              we,
    input  logic              re,
    input  logic              rzero,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DATA_W-1:0] rdata_r;

    // Storage write port; contents survive reset.
    always_ff @(posedge clock) begin
        if (we) begin
            mem_r[idx] <= wdata;
        end
    end

    // Read register; a rejected (misaligned) read returns zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            rdata_r <= '0;
        end else if (re) begin
            rdata_r <= rzero ? '0 : mem_r[idx];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: stalls the pipeline for LAT cycles per access.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 256,
    parameter int LAT    = DM_LAT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_stall,
    output logic              mem_ready,
    output logic              mem_err
);

    localparam int         IDX_W  = $clog2(DEPTH);
    localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

    dm_state_e         state_r;
    logic [3:0]        cnt_r;
    logic              ready_r;
    logic              err_r;
    logic              lat_rd_r;
    logic              lat_wr_r;
    logic [1:0]        lat_lsb_r;
    logic [IDX_W-1:0]  lat_idx_r;
    logic [DATA_W-1:0] lat_wdata_r;

    logic              idle_req_s;
    logic              commit_s;
    logic              op_rd_s;
    logic              op_wr_s;
    logic              op_bad_s;
    logic [IDX_W-1:0]  op_idx_s;
    logic [DATA_W-1:0] op_wdata_s;
    logic              we_s;
    logic              re_s;

    assign idle_req_s = (state_r == DM_IDLE) && (mem_read || mem_write);

    // With LAT=1 the commit edge ends cycle T, so the live request is used directly.
    always_comb begin
        op_rd_s    = lat_rd_r;
        op_wr_s    = lat_wr_r;
        op_bad_s   = misaligned(lat_lsb_r);
        op_idx_s   = lat_idx_r;
        op_wdata_s = lat_wdata_r;
        if (state_r == DM_IDLE) begin
            op_rd_s    = mem_read;
            op_wr_s    = mem_write;
            op_bad_s   = misaligned(addr[1:0]);
            op_idx_s   = addr[IDX_W+1:2];
            op_wdata_s = wdata;
        end else begin
            op_rd_s    = lat_rd_r;
        end
    end

    // Commit edge: the last stall cycle of the request.
    always_comb begin
        commit_s = 1'b0;
        if (LAT == 1) begin
            commit_s = idle_req_s;
        end else begin
            commit_s = (state_r == DM_WAIT) && (cnt_r == LAT_M1);
        end
    end

    assign we_s = commit_s && op_wr_s && !op_bad_s && !reset;
    assign re_s = commit_s && op_rd_s && !op_wr_s && !reset;

    // FSM, latency counter, request latch and sticky error flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= DM_IDLE;
            cnt_r       <= 4'd0;
            ready_r     <= 1'b0;
            err_r       <= 1'b0;
            lat_rd_r    <= 1'b0;
            lat_wr_r    <= 1'b0;
            lat_lsb_r   <= 2'b00;
            lat_idx_r   <= '0;
            lat_wdata_r <= '0;
        end else begin
            case (state_r)
                DM_IDLE: begin
                    ready_r <= 1'b0;
                    if (mem_read || mem_write) begin
                        lat_rd_r    <= mem_read;
                        lat_wr_r    <= mem_write;
                        lat_lsb_r   <= addr[1:0];
                        lat_idx_r   <= addr[IDX_W+1:2];
                        lat_wdata_r <= wdata;
                        err_r       <= err_r | misaligned(addr[1:0]) | (mem_read & mem_write);
                        if (LAT == 1) begin
                            state_r <= DM_DONE;
                            ready_r <= 1'b1;
                        end else begin
                            state_r <= DM_WAIT;
                            cnt_r   <= 4'd1;
                        end
                    end
                end
                DM_WAIT: begin
                    if (cnt_r == LAT_M1) begin
                        state_r <= DM_DONE;
                        ready_r <= 1'b1;
                        cnt_r   <= 4'd0;
                    end else begin
                        cnt_r <= cnt_r + 4'd1;
                    end
                end
                DM_DONE: begin
                    state_r <= DM_IDLE;
                    ready_r <= 1'b0;
                end
                default: begin
                    state_r <= DM_IDLE;
                    ready_r <= 1'b0;
                    cnt_r   <= 4'd0;
                end
            endcase
        end
    end

    assign mem_stall = idle_req_s || (state_r == DM_WAIT);
    assign mem_ready = ready_r;
    assign mem_err   = err_r;

    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clock  (clock),
        .reset  (reset),
        .we     (we_s),
        .re     (re_s),
        .rzero  (op_bad_s),
        .idx    (op_idx_s),
        .wdata  (op_wdata_s),
        .rdata  (rdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Table-driven bench for dmem_responder with LAT=3 and LAT=1 instances and a read-data scoreboard.
module tb_dmem_responder;

    logic        clock = 1'b0;
    logic        reset [2];
    logic        rd    [2];
    logic        wr    [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata [2];
    logic        stall [2];
    logic        ready [2];
    logic        err   [2];

    always #5 clock = ~clock;

    dmem_responder #(.LAT(3)) dut3 (
        .clock(clock), .reset(reset[0]), .mem_read(rd[0]), .mem_write(wr[0]),
        .addr(addr[0]), .wdata(wdata[0]), .rdata(rdata[0]),
        .mem_stall(stall[0]), .mem_ready(ready[0]), .mem_err(err[0])
    );

    dmem_responder #(.LAT(1)) dut1 (
        .clock(clock), .reset(reset[1]), .mem_read(rd[1]), .mem_write(wr[1]),
        .addr(addr[1]), .wdata(wdata[1]), .rdata(rdata[1]),
        .mem_stall(stall[1]), .mem_ready(ready[1]), .mem_err(err[1])
    );

    typedef struct {
        int          d;
        logic        r;
        logic        w;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t        vecs  [$];
    logic [31:0] sb_q  [$];
    logic [31:0] last_rd [2];
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic add(input int d, input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] er, input logic ee);
        vec_t v;
        v.d = d; v.r = r; v.w = w; v.a = a; v.wd = wd; v.exp_rdata = er; v.exp_err = ee;
        vecs.push_back(v);
    endtask

    // Drives one request from cycle T, holds it until DONE, then releases the inputs.
    task automatic access(input vec_t v);
        int          lat;
        int          ns;
        bit          got;
        logic [31:0] expv;
        lat = (v.d == 0) ? 3 : 1;
        ns  = 0;
        got = 1'b0;
        rd[v.d] = v.r; wr[v.d] = v.w; addr[v.d] = v.a; wdata[v.d] = v.wd;
        if (v.r && !v.w) sb_q.push_back(v.exp_rdata);
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clock);
            if (ready[v.d]) got = 1'b1;
            else if (stall[v.d]) ns++;
        end
        chk("ready_seen", 32'(got), 32'd1);
        chk("stall_cycles", 32'(ns), 32'(lat));
        chk("stall_in_done", 32'(stall[v.d]), 32'd0);
        chk("err", 32'(err[v.d]), 32'(v.exp_err));
        if (v.r && !v.w) begin
            expv = sb_q.pop_front();
            chk("rdata", rdata[v.d], expv);
            last_rd[v.d] = expv;
        end else begin
            chk("rdata_hold", rdata[v.d], last_rd[v.d]);
        end
        @(posedge clock); #1;
        rd[v.d] = 1'b0; wr[v.d] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        vec_t v;
        for (int d = 0; d < 2; d++) begin
            reset[d] = 1'b1; rd[d] = 1'b0; wr[d] = 1'b0;
            addr[d] = 32'd0; wdata[d] = 32'd0; last_rd[d] = 32'd0;
        end

        // LAT=3 instance: basic, wrap, misaligned, read+write conflict, sticky error.
        add(0, 1'b0, 1'b1, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0);
        add(0, 1'b1, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0);
        add(0, 1'b0, 1'b1, 32'h400, 32'h12345678, 32'h0,        1'b0);
        add(0, 1'b1, 1'b0, 32'h000, 32'h0,        32'h12345678, 1'b0);
        add(0, 1'b1, 1'b0, 32'h13,  32'h0,        32'h0,        1'b1);
        add(0, 1'b1, 1'b1, 32'h20,  32'h55AA55AA, 32'h0,        1'b1);
        add(0, 1'b1, 1'b0, 32'h20,  32'h0,        32'h55AA55AA, 1'b1);
        add(0, 1'b1, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b1);
        // LAT=1 instance: alternating stores and loads.
        add(1, 1'b0, 1'b1, 32'h0,   32'h11111111, 32'h0,        1'b0);
        add(1, 1'b1, 1'b0, 32'h0,   32'h0,        32'h11111111, 1'b0);
        add(1, 1'b0, 1'b1, 32'h4,   32'h22222222, 32'h0,        1'b0);
        add(1, 1'b1, 1'b0, 32'h4,   32'h0,        32'h22222222, 1'b0);
        add(1, 1'b0, 1'b1, 32'h0,   32'h33333333, 32'h0,        1'b0);
        add(1, 1'b1, 1'b0, 32'h0,   32'h0,        32'h33333333, 1'b0);
        add(1, 1'b1, 1'b0, 32'h4,   32'h0,        32'h22222222, 1'b0);

        repeat (3) @(posedge clock);
        #1;
        reset[0] = 1'b0; reset[1] = 1'b0;

        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            for (int d = 0; d < 2; d++) begin
                chk("idle_stall", 32'(stall[d]), 32'd0);
                chk("idle_ready", 32'(ready[d]), 32'd0);
                chk("idle_rdata", rdata[d], 32'd0);
                chk("idle_err", 32'(err[d]), 32'd0);
            end
        end
        @(posedge clock); #1;

        foreach (vecs[i]) access(vecs[i]);

        // Reset in the 2nd WAIT cycle of a store must discard it.
        v.d = 0; v.r = 1'b0; v.w = 1'b1; v.a = 32'h8; v.wd = 32'h1; v.exp_rdata = 32'h0; v.exp_err = 1'b1;
        access(v);
        wr[0] = 1'b1; addr[0] = 32'h8; wdata[0] = 32'hFFFFFFFF;
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset[0] = 1'b1; wr[0] = 1'b0;
        @(posedge clock); #1;
        reset[0] = 1'b0;
        @(negedge clock);
        chk("rst_stall", 32'(stall[0]), 32'd0);
        chk("rst_ready", 32'(ready[0]), 32'd0);
        chk("rst_err", 32'(err[0]), 32'd0);
        chk("rst_rdata", rdata[0], 32'd0);
        chk("rst_state", 32'(dut3.state_r), 32'd0);
        @(posedge clock); #1;
        last_rd[0] = 32'd0;
        v.r = 1'b1; v.w = 1'b0; v.wd = 32'h0; v.exp_rdata = 32'h1; v.exp_err = 1'b0;
        access(v);

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
